// File: rtl/lcd_rgb_timing.sv
// ============================================================================
//  Module      : lcd_rgb_timing
//  Description : Pixel-clock timing generator for a parallel RGB LCD panel.
//                Optional colour-bar generator under LCD_TEST_PATTERN_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_rgb_timing #(
    parameter int H_SYNC  = 128,
    parameter int H_BACK  = 88,
    parameter int H_DISP  = 800,
    parameter int H_FRONT = 40,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_DISP  = 480,
    parameter int V_FRONT = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lcd_en,
    input  logic [23:0] pixel_data,
    output logic        data_req,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [23:0] lcd_rgb,
    output logic        frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam logic [10:0] C_H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] C_V_LAST  = 11'(V_TOTAL - 1);
    localparam logic [10:0] C_H_SYNC  = 11'(H_SYNC);
    localparam logic [10:0] C_V_SYNC  = 11'(V_SYNC);
    localparam logic [10:0] C_H_ACT_S = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] C_V_ACT_S = 11'(V_SYNC + V_BACK);
    // End bounds may equal 2048, so they are compared at 12 bits.
    localparam logic [11:0] C_H_ACT_E = 12'(H_SYNC + H_BACK + H_DISP);
    localparam logic [11:0] C_V_ACT_E = 12'(V_SYNC + V_BACK + V_DISP);

    logic [10:0] r_h_cnt;
    logic [10:0] r_v_cnt;
    logic        r_hs;
    logic        r_vs;
    logic        r_de;
    logic [23:0] r_rgb;
    logic        r_frame_start;

    logic        w_h_last;
    logic        w_v_last;
    logic        w_h_act;
    logic        w_v_act;
    logic        w_active;
    logic [10:0] w_xpos;
    logic [10:0] w_ypos;
    logic [23:0] w_rgb_src;

    assign w_h_last = (r_h_cnt == C_H_LAST);
    assign w_v_last = (r_v_cnt == C_V_LAST);
    assign w_h_act  = (r_h_cnt >= C_H_ACT_S) && ({1'b0, r_h_cnt} < C_H_ACT_E);
    assign w_v_act  = (r_v_cnt >= C_V_ACT_S) && ({1'b0, r_v_cnt} < C_V_ACT_E);
    // Gating by lcd_en makes the request drop in the same cycle enable falls.
    assign w_active = lcd_en && w_h_act && w_v_act;
    assign w_xpos   = w_active ? (r_h_cnt - C_H_ACT_S) : 11'd0;
    assign w_ypos   = w_active ? (r_v_cnt - C_V_ACT_S) : 11'd0;

    assign data_req   = w_active;
    assign pixel_xpos = w_xpos;
    assign pixel_ypos = w_ypos;

`ifdef LCD_TEST_PATTERN_EN
    localparam int BAR_W = H_DISP / 8;

    logic [2:0] w_bar;
    logic       w_unused_pixel;

    assign w_bar          = 3'(w_xpos / 11'(BAR_W));
    assign w_unused_pixel = ^pixel_data;

    always_comb begin
        w_rgb_src = 24'h000000;
        case (w_bar)
            3'd0:    w_rgb_src = 24'hFFFFFF;
            3'd1:    w_rgb_src = 24'hFFFF00;
            3'd2:    w_rgb_src = 24'h00FFFF;
            3'd3:    w_rgb_src = 24'h00FF00;
            3'd4:    w_rgb_src = 24'hFF00FF;
            3'd5:    w_rgb_src = 24'hFF0000;
            3'd6:    w_rgb_src = 24'h0000FF;
            default: w_rgb_src = 24'h000000;
        endcase
    end
`else
    assign w_rgb_src = pixel_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= 11'd0;
            r_v_cnt <= 11'd0;
        end else if (!lcd_en) begin
            r_h_cnt <= 11'd0;
            r_v_cnt <= 11'd0;
        end else if (w_h_last) begin
            r_h_cnt <= 11'd0;
            r_v_cnt <= w_v_last ? 11'd0 : (r_v_cnt + 11'd1);
        end else begin
            r_h_cnt <= r_h_cnt + 11'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_de          <= 1'b0;
            r_rgb         <= 24'h000000;
            r_frame_start <= 1'b0;
        end else if (!lcd_en) begin
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_de          <= 1'b0;
            r_rgb         <= 24'h000000;
            r_frame_start <= 1'b0;
        end else begin
            r_hs          <= ~(r_h_cnt < C_H_SYNC);
            r_vs          <= ~(r_v_cnt < C_V_SYNC);
            r_de          <= w_active;
            r_rgb         <= w_active ? w_rgb_src : 24'h000000;
            r_frame_start <= (r_h_cnt == 11'd0) && (r_v_cnt == 11'd0);
        end
    end

    assign lcd_hs      = r_hs;
    assign lcd_vs      = r_vs;
    assign lcd_de      = r_de;
    assign lcd_rgb     = r_rgb;
    assign frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: doc/lcd_rgb_timing.md
Name: lcd_rgb_timing

Overview:
- Pixel-clock-domain timing generator for the parallel RGB LCD panel.
- Runs on the divided pixel clock produced upstream and is the consumer of that clock.
- Generates HSYNC, VSYNC and DE, and requests pixel data from the character/graphics renderer one cycle ahead with an (x,y) coordinate.
- Drives the registered 24-bit RGB bus to the panel pins.

Parameters:
- H_SYNC, 128, HSYNC pulse width in pclk cycles (>=1)
- H_BACK, 88, horizontal back porch in cycles
- H_DISP, 800, active pixels per line (multiple of 8)
- H_FRONT, 40, horizontal front porch in cycles
- V_SYNC, 2, VSYNC pulse width in lines (>=1)
- V_BACK, 33, vertical back porch in lines
- V_DISP, 480, active lines per frame
- V_FRONT, 10, vertical front porch in lines
- Derived: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*. Both must be <= 2048.

Ports:
- clk  in  1  pixel clock; all logic on posedge
- rst_n  in  1  reset
- lcd_en  in  1  timing enable; low = hold idle
- pixel_data  in  24  RGB888 from renderer, valid in the same cycle as data_req
- data_req  out  1  combinational: current counters are inside the active window
- pixel_xpos  out  11  combinational: active column 0..H_DISP-1; 0 when data_req=0
- pixel_ypos  out  11  combinational: active line 0..V_DISP-1; 0 when data_req=0
- lcd_hs  out  1  HSYNC, active low, registered
- lcd_vs  out  1  VSYNC, active low, registered
- lcd_de  out  1  data enable, registered
- lcd_rgb  out  24  pixel bus, registered
- frame_start  out  1  one-cycle pulse, registered

Interface decision: reset rst_n, asynchronous, active-low; clock clk.

Behaviour:
- Counters:
  - 11-bit h_cnt runs 0..H_TOTAL-1. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt runs 0..V_TOTAL-1 and wraps to 0 when h_cnt and v_cnt are both at terminal count.
- Active window: h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP).
- data_req = active window, combinational.
  - pixel_xpos = h_cnt-(H_SYNC+H_BACK); pixel_ypos = v_cnt-(V_SYNC+V_BACK).
- Registered outputs, 1-cycle latency relative to counters, all mutually aligned:
  - lcd_hs <= ~(h_cnt < H_SYNC); lcd_vs <= ~(v_cnt < V_SYNC).
  - lcd_de <= data_req; lcd_rgb <= data_req ? pixel_data : 24'h0.
  - frame_start <= (h_cnt==0 && v_cnt==0 && lcd_en).
- Reset: h_cnt=v_cnt=0; lcd_hs=1, lcd_vs=1, lcd_de=0, lcd_rgb=0, frame_start=0. data_req=0, since H_SYNC>=1 keeps (0,0) outside the active window.
- lcd_en low:
  - Counters are forced to 0 on the next edge.
  - Registered outputs take reset values on the next edge; data_req is gated to 0 immediately.
- lcd_en deasserted mid-frame: the frame is aborted with no partial-line completion.
- lcd_en reasserted: counting starts from (0,0). frame_start pulses on the edge after the first enabled cycle.
- Asynchronous reset mid-frame: immediate return to reset values, same restart rule as lcd_en.
- No back-pressure: the renderer must supply pixel_data combinationally in the data_req cycle. A registered renderer must look ahead itself.

Optional Feature:
- Macro LCD_TEST_PATTERN_EN.
- Defined:
  - pixel_data is ignored.
  - lcd_rgb is driven from eight vertical colour bars, bar index = pixel_xpos / (H_DISP/8).
  - Bar order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Same 1-cycle registered timing as normal mode; blanking still 0.
- Undefined: pass-through as above, with no pattern logic synthesised.

Test Plan:
Bench parameters: H 2/3/8/2 (H_TOTAL=15), V 1/2/4/1 (V_TOTAL=8).
1. Reset release, lcd_en=1 -> frame_start high at cycle 1 only, next pulse exactly 120 cycles later. lcd_hs low for 2 of every 15 cycles. lcd_vs low for the first 15 cycles of each frame.
2. pixel_data = {8'h0, ypos[7:0], xpos[7:0]} -> lcd_de high 8 cycles per line on lines 3..6 only, 32 cycles per frame. lcd_rgb = 000000..000007 on the first active line and 000300..000307 on the last. lcd_rgb=0 whenever lcd_de=0.
3. Alignment check -> lcd_de rises exactly 1 cycle after data_req and falls 1 cycle after it. lcd_hs/lcd_de edges match the counter values + 1 cycle.
4. lcd_en low at h_cnt=9, v_cnt=4 for 5 cycles, then high -> next edge gives hs=vs=1, de=0, rgb=0, data_req=0. Restart produces frame_start 1 cycle after re-enable and a full 120-cycle frame follows.
5. rst_n pulsed low mid-line -> outputs go to reset values asynchronously, without waiting for a clk edge. Timing restarts at (0,0).
6. LCD_TEST_PATTERN_EN defined -> active line lcd_rgb sequence is FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000 regardless of pixel_data.
